chunked_addsub: RTL and testbench

//  Multi-cycle, parametrised add/subtract unit with an NZCV flag register.

---
 rtl/chunked_addsub_if.sv | 24 ++
 rtl/chunked_addsub.sv | 125 ++++++++++++
 tb/tb_chunked_addsub.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/chunked_addsub_if.sv
// Launch/result bundle for chunked_addsub: operands and controls in, Result/Flag/status out.
interface chunked_addsub_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             Op;
    logic             S;
    logic [WIDTH-1:0] In1;
    logic [WIDTH-1:0] In2;
    logic [WIDTH-1:0] Result;
    logic [3:0]       Flag;
    logic             busy;
    logic             done;

    modport master (
        output start, Op, S, In1, In2,
        input  Result, Flag, busy, done
    );

    modport slave (
        input  start, Op, S, In1, In2,
        output Result, Flag, busy, done
    );
endinterface

// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract: CHUNK bits per cycle with rippled carry, NZCV flags on completion.
// Optional ADDSUB_SAT_EN clamps overflowing results to the signed extreme.
module chunked_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input logic             clk,
    input logic             rst_n,
    chunked_addsub_if.slave bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(NCHUNK - 1);

    typedef enum logic {StIdle, StRun} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flag;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_s;
    logic             r_done;

    logic             w_accept;
    logic             w_last;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_chunk_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic [3:0]       w_flags;

    assign w_accept = bus.start && (r_state == StIdle);
    assign w_last   = (r_state == StRun) && (r_cnt == LastCnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (bus.start) w_state_next = StRun;
            StRun:  if (r_cnt == LastCnt) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // One chunk of A + B' + carry; w_sum is the shadow with this chunk merged in,
    // so the final edge can publish the complete sum without an extra cycle.
    always_comb begin
        w_a_chunk = r_a[int'(r_cnt) * CHUNK +: CHUNK];
        w_b_chunk = r_b[int'(r_cnt) * CHUNK +: CHUNK];
        {w_cout, w_chunk_sum} = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
        w_sum = r_sum;
        w_sum[int'(r_cnt) * CHUNK +: CHUNK] = w_chunk_sum;
    end

    assign w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);

`ifdef ADDSUB_SAT_EN
    always_comb begin
        w_res = w_sum;
        if (w_ovf) begin
            w_res = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_res = w_sum;
`endif

    // N/Z follow the published result; C/V always come from the raw sum.
    assign w_flags = {w_res[WIDTH-1], (w_res == '0), w_cout, w_ovf};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_result <= '0;
            r_flag   <= 4'b0000;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_s      <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_a     <= bus.In1;
                r_b     <= bus.Op ? ~bus.In2 : bus.In2;
                r_carry <= bus.Op;
                r_s     <= bus.S;
                r_cnt   <= '0;
                r_sum   <= '0;
            end else if (r_state == StRun) begin
                r_sum   <= w_sum;
                r_carry <= w_cout;
                r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
                if (w_last) begin
                    r_result <= w_res;
                    if (r_s) begin
                        r_flag <= w_flags;
                    end
                end
            end
        end
    end

    assign bus.Result = r_result;
    assign bus.Flag   = r_flag;
    assign bus.busy   = (r_state == StRun);
    assign bus.done   = r_done;

endmodule

// File: tb/tb_chunked_addsub.sv
// Self-checking bench for chunked_addsub: behavioural model + per-cycle compare, directed and random ops.
module tb_chunked_addsub;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CHUNK  = 8;
    localparam int unsigned NCHUNK = WIDTH / CHUNK;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    chunked_addsub_if #(.WIDTH(WIDTH)) bus ();

    chunked_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {flags, result} from plain signed arithmetic.
    function automatic logic [35:0] ref_op(input logic op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] raw;
        longint      sa, sb, full;
        logic        v;
        logic [31:0] res;
        raw  = op ? ({1'b0, a} + {1'b0, ~b} + 33'd1) : ({1'b0, a} + {1'b0, b});
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        full = op ? (sa - sb) : (sa + sb);
        v    = (full > 64'sd2147483647) || (full < -64'sd2147483648);
        res  = raw[31:0];
`ifdef ADDSUB_SAT_EN
        if (v) res = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {res[31], (res == 32'd0), raw[32], v, res};
    endfunction

    // Model state, advanced on the same edges as the DUT.
    logic        m_busy, m_done, p_s;
    logic [31:0] m_result;
    logic [3:0]  m_flag;
    logic [35:0] p_pack;
    int          m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_result <= '0;
            m_flag   <= '0;
            m_left   <= 0;
            p_s      <= 1'b0;
            p_pack   <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy   <= 1'b0;
                    m_done   <= 1'b1;
                    m_result <= p_pack[31:0];
                    if (p_s) m_flag <= p_pack[35:32];
                end
            end else if (bus.start) begin
                m_busy <= 1'b1;
                m_left <= NCHUNK;
                p_s    <= bus.S;
                p_pack <= ref_op(bus.Op, bus.In1, bus.In2);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("cyc_busy", 32'(bus.busy), 32'(m_busy));
        check("cyc_done", 32'(bus.done), 32'(m_done));
        check("cyc_result", bus.Result, m_result);
        check("cyc_flag", 32'(bus.Flag), 32'(m_flag));
    end

    task automatic wait_idle();
        int k = 0;
        while (bus.busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (bus.busy) check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic launch(input logic op, input logic s, input logic [31:0] a, input logic [31:0] b);
        wait_idle();
        bus.start = 1'b1;
        bus.Op    = op;
        bus.S     = s;
        bus.In1   = a;
        bus.In2   = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.Op    = 1'($urandom);
        bus.S     = 1'($urandom);
        bus.In1   = $urandom;
        bus.In2   = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.done) check("done_timeout", 32'(bus.done), 32'd1);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] edges [6];
        edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_00FF};
        return ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
    endfunction

    initial begin
        int          lat;
        logic [35:0] pk;
        logic [3:0]  prev_flag;
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.Op    = 1'b0;
        bus.S     = 1'b0;
        bus.In1   = '0;
        bus.In2   = '0;

        pk = ref_op(1'b1, 32'd2, 32'd3);
        check("model_2m3", pk[31:0], 32'hFFFF_FFFF);
        check("model_2m3_flag", 32'(pk[35:32]), 32'h8);
        pk = ref_op(1'b0, 32'h7FFF_FFFF, 32'd1);
`ifdef ADDSUB_SAT_EN
        check("model_max_p1", pk[31:0], 32'h7FFF_FFFF);
        check("model_max_p1_flag", 32'(pk[35:32]), 32'h1);
`else
        check("model_max_p1", pk[31:0], 32'h8000_0000);
        check("model_max_p1_flag", 32'(pk[35:32]), 32'h9);
`endif

        repeat (3) @(negedge clk);
        check("rst_result", bus.Result, 32'd0);
        check("rst_flag", 32'(bus.Flag), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        launch(1'b1, 1'b1, 32'd2, 32'd3);
        wait_done(lat);
        check("t1_latency", 32'(lat), 32'd4);
        check("t1_result", bus.Result, 32'hFFFF_FFFF);
        check("t1_flag", 32'(bus.Flag), 32'b1000);
        check("t1_busy_in_done", 32'(bus.busy), 32'd0);

        launch(1'b1, 1'b1, 32'd10, 32'd10);
        wait_done(lat);
        check("t2_result", bus.Result, 32'd0);
        check("t2_flag", 32'(bus.Flag), 32'b0110);

        launch(1'b1, 1'b1, 32'h8000_0000, 32'd1);
        wait_done(lat);
`ifdef ADDSUB_SAT_EN
        check("t3_result", bus.Result, 32'h8000_0000);
        check("t3_flag", 32'(bus.Flag), 32'b1011);
`else
        check("t3_result", bus.Result, 32'h7FFF_FFFF);
        check("t3_flag", 32'(bus.Flag), 32'b0011);
`endif
        prev_flag = bus.Flag;

        launch(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
        wait_done(lat);
        check("t4_result", bus.Result, 32'd0);
        check("t4_flag_hold", 32'(bus.Flag), 32'(prev_flag));

        launch(1'b0, 1'b1, 32'd100, 32'd23);
        @(negedge clk);
        bus.start = 1'b1;
        bus.Op    = 1'b1;
        bus.In1   = 32'd5;
        bus.In2   = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        check("t5_result", bus.Result, 32'd123);
        check("t5_flag", 32'(bus.Flag), 32'b0000);

        launch(1'b1, 1'b1, 32'd2, 32'd3);
        wait_done(lat);
        launch(1'b1, 1'b1, 32'd7, 32'd9);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 32'(bus.busy), 32'd0);
        check("t5_rst_done", 32'(bus.done), 32'd0);
        check("t5_rst_result", bus.Result, 32'd0);
        check("t5_rst_flag", 32'(bus.Flag), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(negedge clk);

        wait_idle();
        bus.start = 1'b1;
        bus.Op    = 1'b1;
        bus.S     = 1'b1;
        bus.In1   = 32'd2;
        bus.In2   = 32'd3;
        @(negedge clk);
        bus.In1 = 32'd1;
        bus.In2 = 32'hFFFF_FFFD;
        wait_done(lat);
        check("t6_first_result", bus.Result, 32'hFFFF_FFFF);
        @(negedge clk);
        bus.start = 1'b0;
        check("t6_no_gap_busy", 32'(bus.busy), 32'd1);
        wait_done(lat);
        check("t6_latency", 32'(lat), 32'd4);
        check("t6_result", bus.Result, 32'd4);
        check("t6_flag", 32'(bus.Flag), 32'b0000);

        for (int i = 0; i < 300; i++) begin
            launch(1'($urandom), 1'($urandom), pick(), pick());
            if ($urandom_range(0, 3) == 0) begin
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
            end
            wait_done(lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
